universal_shift_reg: RTL and testbench

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

---
 rtl/universal_shift_reg.sv | 92 +++++++++
 tb/tb_universal_shift_reg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a same-direction shift counter that saturates at WIDTH and a full flag.
module universal_shift_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         d,
  input  logic [WIDTH-1:0]             pd,
  output logic [WIDTH-1:0]             q,
  output logic                         so_r,
  output logic                         so_l,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full
);

  localparam int unsigned   CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SHR  = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  dir_e             dir;
  dir_e             dir_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;
  logic             full_nxt;

  // State register; en=0 freezes everything including the last direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= RST_VAL;
      cnt  <= '0;
      full <= 1'b0;
      dir  <= DIR_NONE;
    end else if (en) begin
      q    <= q_nxt;
      cnt  <= cnt_nxt;
      full <= full_nxt;
      dir  <= dir_nxt;
    end
  end

  // Next-state: a shift that continues the last direction counts up
  // (saturating), anything else restarts the run at one.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    dir_nxt = dir;
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    case (mode_e'(mode))
      MODE_HOLD: begin
        q_nxt = q;
      end
      MODE_SHR: begin
        q_nxt   = {d, q[WIDTH-1:1]};
        dir_nxt = DIR_RIGHT;
        cnt_nxt = (dir == DIR_RIGHT) ? cnt_inc : CNT_ONE;
      end
      MODE_SHL: begin
        q_nxt   = {q[WIDTH-2:0], d};
        dir_nxt = DIR_LEFT;
        cnt_nxt = (dir == DIR_LEFT) ? cnt_inc : CNT_ONE;
      end
      MODE_LOAD: begin
        q_nxt   = pd;
        dir_nxt = DIR_NONE;
        cnt_nxt = '0;
      end
    endcase
    full_nxt = (cnt_nxt == CNT_MAX);
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed scoreboard bench for universal_shift_reg (WIDTH=8): stimulus
// pushes expected post-edge state, a monitor pops and compares after each edge.
module tb_universal_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       d;
  logic [7:0] pd;
  logic [7:0] q;
  logic       so_r;
  logic       so_l;
  logic [3:0] cnt;
  logic       full;

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
    logic       full;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  universal_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .d    (d),
    .pd   (pd),
    .q    (q),
    .so_r (so_r),
    .so_l (so_l),
    .cnt  (cnt),
    .full (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] eq,
                       input logic [3:0] ec, input logic ef);
    logic [7:0] e;
    e = eq;
    checks++;
    if (q !== e || cnt !== ec || full !== ef || so_r !== e[0] || so_l !== e[7]) begin
      failures++;
      $display("FAIL %s: got q=%h cnt=%0d full=%b so_r=%b so_l=%b, want q=%h cnt=%0d full=%b so_r=%b so_l=%b",
               name, q, cnt, full, so_r, so_l, e, ec, ef, e[0], e[7]);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input logic s_en, input logic [1:0] s_mode, input logic s_d,
                      input logic [7:0] s_pd, input logic [7:0] eq,
                      input logic [3:0] ec, input logic ef, input string name);
    exp_t e;
    @(negedge clk);
    en   = s_en;
    mode = s_mode;
    d    = s_d;
    pd   = s_pd;
    e.q = eq; e.cnt = ec; e.full = ef; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per edge while stimulus is active.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check(mon_e.name, mon_e.q, mon_e.cnt, mon_e.full);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; d = 1'b0; pd = 8'h00;
    #1;
    check("reset_initial", 8'h00, 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Serial-in from reset, shifting left.
    step(1, 2'b10, 1, 8'h00, 8'h01, 4'd1, 0, "shl_1");
    step(1, 2'b10, 0, 8'h00, 8'h02, 4'd2, 0, "shl_2");
    step(1, 2'b10, 1, 8'h00, 8'h05, 4'd3, 0, "shl_3");
    step(1, 2'b10, 1, 8'h00, 8'h0B, 4'd4, 0, "shl_4");
    step(1, 2'b10, 0, 8'h00, 8'h16, 4'd5, 0, "shl_5");
    step(1, 2'b10, 1, 8'h00, 8'h2D, 4'd6, 0, "shl_6");
    step(1, 2'b10, 0, 8'h00, 8'h5A, 4'd7, 0, "shl_7");
    step(1, 2'b10, 0, 8'h00, 8'hB4, 4'd8, 1, "shl_8_full");
    step(1, 2'b10, 0, 8'h00, 8'h68, 4'd8, 1, "shl_9_sat");

    // Disabled cycles and explicit hold leave all state alone.
    step(0, 2'b01, 1, 8'hFF, 8'h68, 4'd8, 1, "en0_shr");
    step(0, 2'b10, 1, 8'hFF, 8'h68, 4'd8, 1, "en0_shl");
    step(0, 2'b11, 1, 8'hFF, 8'h68, 4'd8, 1, "en0_load");
    step(0, 2'b01, 0, 8'hFF, 8'h68, 4'd8, 1, "en0_shr_b");
    step(0, 2'b11, 0, 8'hFF, 8'h68, 4'd8, 1, "en0_load_b");
    step(1, 2'b00, 1, 8'hFF, 8'h68, 4'd8, 1, "hold_1");
    step(1, 2'b00, 0, 8'hFF, 8'h68, 4'd8, 1, "hold_2");

    // Load from full clears count and flag.
    step(1, 2'b11, 0, 8'h3C, 8'h3C, 4'd0, 0, "load_3c");

    // Direction reversal restarts the run count.
    step(1, 2'b10, 1, 8'h00, 8'h79, 4'd1, 0, "rev_shl_1");
    step(1, 2'b10, 1, 8'h00, 8'hF3, 4'd2, 0, "rev_shl_2");
    step(1, 2'b10, 1, 8'h00, 8'hE7, 4'd3, 0, "rev_shl_3");
    step(1, 2'b01, 0, 8'h00, 8'h73, 4'd1, 0, "rev_shr");
    step(1, 2'b10, 0, 8'h00, 8'hE6, 4'd1, 0, "rev_shl_again");
    step(0, 2'b01, 1, 8'h00, 8'hE6, 4'd1, 0, "en0_keeps_dir");
    step(1, 2'b10, 1, 8'h00, 8'hCD, 4'd2, 0, "dir_held_shl");
    step(1, 2'b00, 1, 8'h00, 8'hCD, 4'd2, 0, "hold_keeps_dir");
    step(1, 2'b10, 0, 8'h00, 8'h9A, 4'd3, 0, "dir_held_shl_2");

    // Load A5 then shift right eight times; so_r emits 1,0,1,0,0,1,0,1.
    step(1, 2'b11, 0, 8'hA5, 8'hA5, 4'd0, 0, "load_a5");
    step(1, 2'b01, 0, 8'h00, 8'h52, 4'd1, 0, "shr_1");
    step(1, 2'b01, 0, 8'h00, 8'h29, 4'd2, 0, "shr_2");
    step(1, 2'b01, 0, 8'h00, 8'h14, 4'd3, 0, "shr_3");
    step(1, 2'b01, 0, 8'h00, 8'h0A, 4'd4, 0, "shr_4");
    step(1, 2'b01, 0, 8'h00, 8'h05, 4'd5, 0, "shr_5");
    step(1, 2'b01, 0, 8'h00, 8'h02, 4'd6, 0, "shr_6");
    step(1, 2'b01, 0, 8'h00, 8'h01, 4'd7, 0, "shr_7");
    step(1, 2'b01, 0, 8'h00, 8'h00, 4'd8, 1, "shr_8_full");
    step(1, 2'b10, 1, 8'h00, 8'h01, 4'd1, 0, "full_reversal");
    step(1, 2'b10, 1, 8'h00, 8'h03, 4'd2, 0, "pre_rst_shl");

    // Mid-cycle asynchronous reset pulse, no clock edge involved.
    @(negedge clk);
    en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("async_reset", 8'h00, 4'd0, 1'b0);
    #1 rst = 1'b1;

    // After reset the direction is NONE, so a left shift starts at one.
    step(1, 2'b10, 1, 8'h00, 8'h01, 4'd1, 0, "post_rst_shl");
    step(1, 2'b01, 1, 8'h00, 8'h80, 4'd1, 0, "post_rst_shr");

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
